ahb_sram_ctrl: RTL and testbench

- AHB-Lite slave SRAM controller for 32-bit on-chip data storage; sits on the AHB bus as a zero-wait-state memory slave.
- Decodes AHB transfers into byte-enabled accesses to an internal word-organised SRAM array.
- Reads return data in the AHB data phase; writes commit at the end of the data phase.

---
 rtl/ahb_sram_ctrl_pkg.sv | 30 +++
 rtl/ahb_sram_ctrl_sram_core.sv | 30 +++
 rtl/ahb_sram_ctrl.sv | 153 +++++++++++++++
 tb/tb_ahb_sram_ctrl.sv | 197 +++++++++++++++++++
 4 files changed

// File: rtl/ahb_sram_ctrl_pkg.sv
// Shared AHB encodings, self-test patterns and the byte-lane decode used by ahb_sram_ctrl.
// Pure declarations: no latency, no flow control.
package ahb_sram_ctrl_pkg;

  localparam logic [1:0] HTRANS_IDLE   = 2'b00;
  localparam logic [1:0] HTRANS_BUSY   = 2'b01;
  localparam logic [1:0] HTRANS_NONSEQ = 2'b10;
  localparam logic [1:0] HTRANS_SEQ    = 2'b11;

  localparam logic [2:0] HSIZE_BYTE = 3'b000;
  localparam logic [2:0] HSIZE_HALF = 3'b001;
  localparam logic [2:0] HSIZE_WORD = 3'b010;

  localparam logic [1:0] HRESP_OKAY = 2'b00;

  localparam logic [31:0] BIST_PAT0 = 32'h5555_5555;
  localparam logic [31:0] BIST_PAT1 = 32'hAAAA_AAAA;

  // Sizes above a word still drive all four lanes.
  function automatic logic [3:0] byte_en(input logic [2:0] size, input logic [1:0] addr_lo);
    logic [3:0] be;
    case (size)
      HSIZE_BYTE: be = 4'b0001 << addr_lo;
      HSIZE_HALF: be = addr_lo[1] ? 4'b1100 : 4'b0011;
      default:    be = 4'b1111;
    endcase
    return be;
  endfunction

endpackage

// File: rtl/ahb_sram_ctrl_sram_core.sv
// Word SRAM: byte-enabled write on rising edge, read into a reset-able output register on falling edge.
// One-half-cycle read latency; no backpressure.
module ahb_sram_ctrl_sram_core #(
  parameter int AW = 14
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic [3:0]    be,
  input  logic [AW-1:0] waddr,
  input  logic [31:0]   wdata,
  input  logic          re,
  input  logic [AW-1:0] raddr,
  output logic [31:0]   rdata
);

  logic [31:0] mem [0:(1<<AW)-1];

  always_ff @(posedge clk) begin
    for (int i = 0; i < 4; i++) begin
      if (be[i]) mem[waddr][8*i +: 8] <= wdata[8*i +: 8];
    end
  end

  // Falling-edge read sees a write committed at the preceding rising edge.
  always_ff @(negedge clk or negedge rst_n) begin
    if (!rst_n)  rdata <= '0;
    else if (re) rdata <= mem[raddr];
  end

endmodule

// File: rtl/ahb_sram_ctrl.sv
// Zero-wait AHB-Lite SRAM slave; read data valid mid data phase, writes commit at data-phase end.
// hready_resp only drops while the SRAMC_BIST_EN march self-test runs (transfers ignored then).
import ahb_sram_ctrl_pkg::*;

module ahb_sram_ctrl #(
  parameter int ADDR_WIDTH = 16,
  parameter int DATA_WIDTH = 32
) (
  input  logic                  hclk,
  input  logic                  hresetn,
  input  logic                  hsel,
  input  logic                  hwrite,
  input  logic                  hready,
  input  logic [2:0]            hsize,
  input  logic [2:0]            hburst,
  input  logic [1:0]            htrans,
  input  logic [DATA_WIDTH-1:0] hwdata,
  input  logic [31:0]           haddr,
  input  logic                  dft_en,
  input  logic                  bist_en,
  output logic                  hready_resp,
  output logic [1:0]            hresp,
  output logic [DATA_WIDTH-1:0] hrdata,
  output logic                  bist_done,
  output logic                  bist_fail
);

  localparam int AW = ADDR_WIDTH - 2;

  logic                  run;
  logic                  xfer;
  logic                  dp_vld;
  logic                  dp_write;
  logic [ADDR_WIDTH-1:0] dp_addr;
  logic [2:0]            dp_size;
  logic [3:0]            ahb_be;
  logic                  ahb_re;
  logic [3:0]            mem_be;
  logic [AW-1:0]         mem_addr;
  logic [31:0]           mem_wdata;
  logic                  mem_re;

  assign xfer = hsel & hready & ((htrans == HTRANS_NONSEQ) | (htrans == HTRANS_SEQ)) & ~run;

  always_ff @(posedge hclk or negedge hresetn) begin
    if (!hresetn) begin
      dp_vld   <= 1'b0;
      dp_write <= 1'b0;
      dp_addr  <= '0;
      dp_size  <= '0;
    end else begin
      dp_vld <= xfer;
      if (xfer) begin
        dp_write <= hwrite;
        dp_addr  <= haddr[ADDR_WIDTH-1:0];
        dp_size  <= hsize;
      end
    end
  end

  assign ahb_be = (dp_vld & dp_write) ? byte_en(dp_size, dp_addr[1:0]) : 4'b0000;
  assign ahb_re = dp_vld & ~dp_write;

  assign hready_resp = ~run;
  assign hresp       = HRESP_OKAY;

`ifdef SRAMC_BIST_EN
  localparam logic [2:0] B_IDLE = 3'd0;
  localparam logic [2:0] B_W0   = 3'd1;
  localparam logic [2:0] B_R0   = 3'd2;
  localparam logic [2:0] B_W1   = 3'd3;
  localparam logic [2:0] B_R1   = 3'd4;
  localparam logic [2:0] B_DONE = 3'd5;

  logic [2:0]    b_state;
  logic [AW-1:0] b_cnt;
  logic          b_en_q;
  logic          b_last;

  assign run    = (b_state == B_W0) | (b_state == B_R0) | (b_state == B_W1) | (b_state == B_R1);
  assign b_last = &b_cnt;

  // Read states compare the word fetched at this cycle's falling edge.
  always_ff @(posedge hclk or negedge hresetn) begin
    if (!hresetn) begin
      b_state   <= B_IDLE;
      b_cnt     <= '0;
      b_en_q    <= 1'b0;
      bist_fail <= 1'b0;
    end else begin
      b_en_q <= bist_en;
      case (b_state)
        B_IDLE: if (bist_en & ~b_en_q) begin
          b_state <= B_W0;
          b_cnt   <= '0;
        end
        B_W0: begin
          b_cnt <= b_cnt + 1'b1;
          if (b_last) b_state <= B_R0;
        end
        B_R0: begin
          if (hrdata != BIST_PAT0) bist_fail <= 1'b1;
          b_cnt <= b_cnt + 1'b1;
          if (b_last) b_state <= B_W1;
        end
        B_W1: begin
          b_cnt <= b_cnt + 1'b1;
          if (b_last) b_state <= B_R1;
        end
        B_R1: begin
          if (hrdata != BIST_PAT1) bist_fail <= 1'b1;
          b_cnt <= b_cnt + 1'b1;
          if (b_last) b_state <= B_DONE;
        end
        B_DONE:  if (!bist_en) b_state <= B_IDLE;
        default: b_state <= B_IDLE;
      endcase
    end
  end

  assign bist_done = (b_state == B_DONE);
  assign mem_be    = ((b_state == B_W0) | (b_state == B_W1)) ? 4'b1111 : ahb_be;
  assign mem_wdata = (b_state == B_W0) ? BIST_PAT0 : (b_state == B_W1) ? BIST_PAT1 : hwdata;
  assign mem_addr  = run ? b_cnt : dp_addr[ADDR_WIDTH-1:2];
  assign mem_re    = (b_state == B_R0) | (b_state == B_R1) | ahb_re;

  logic unused_ok;
  assign unused_ok = ^{dft_en, hburst, haddr[31:ADDR_WIDTH]};
`else
  assign run       = 1'b0;
  assign bist_done = 1'b0;
  assign bist_fail = 1'b0;
  assign mem_be    = ahb_be;
  assign mem_wdata = hwdata;
  assign mem_addr  = dp_addr[ADDR_WIDTH-1:2];
  assign mem_re    = ahb_re;

  logic unused_ok;
  assign unused_ok = ^{dft_en, bist_en, hburst, haddr[31:ADDR_WIDTH]};
`endif

  ahb_sram_ctrl_sram_core #(.AW(AW)) u_sram_core (
    .clk   (hclk),
    .rst_n (hresetn),
    .be    (mem_be),
    .waddr (mem_addr),
    .wdata (mem_wdata),
    .re    (mem_re),
    .raddr (mem_addr),
    .rdata (hrdata)
  );

endmodule

// File: tb/tb_ahb_sram_ctrl.sv
// Drives pipelined AHB transfers at ahb_sram_ctrl and checks read data against a byte-addressed memory model.
module tb_ahb_sram_ctrl;

  logic        hclk = 1'b0;
  logic        hresetn;
  logic        hsel, hwrite, hready;
  logic [2:0]  hsize, hburst;
  logic [1:0]  htrans;
  logic [31:0] hwdata, haddr;
  logic        dft_en, bist_en;
  logic        hready_resp;
  logic [1:0]  hresp;
  logic [31:0] hrdata;
  logic        bist_done, bist_fail;

  always #5 hclk = ~hclk;

  ahb_sram_ctrl dut (
    .hclk(hclk), .hresetn(hresetn), .hsel(hsel), .hwrite(hwrite), .hready(hready),
    .hsize(hsize), .hburst(hburst), .htrans(htrans), .hwdata(hwdata), .haddr(haddr),
    .dft_en(dft_en), .bist_en(bist_en), .hready_resp(hready_resp), .hresp(hresp),
    .hrdata(hrdata), .bist_done(bist_done), .bist_fail(bist_fail)
  );

  int total = 0;
  int bad   = 0;

  // Reference memory: one entry per byte of the 64 KB decoded space.
  logic [7:0] mdl [0:65535];

  bit          pend_vld = 1'b0;
  bit          pend_wr;
  logic [2:0]  pend_size;
  logic [31:0] pend_addr;
  logic [31:0] pend_wdata;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    if (obs !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h", tag, obs, exp);
    end
  endtask

  function automatic void mdl_write(input logic [31:0] a, input logic [2:0] sz, input logic [31:0] d);
    int n;
    int base;
    n    = (sz >= 3'd2) ? 4 : (1 << sz);
    base = int'(a[15:0]) - (int'(a[15:0]) % n);
    for (int k = 0; k < n; k++) mdl[base + k] = d[8*((base + k) % 4) +: 8];
  endfunction

  function automatic logic [31:0] mdl_read(input logic [31:0] a);
    int w;
    w = int'(a[15:0]) - (int'(a[15:0]) % 4);
    return {mdl[w + 3], mdl[w + 2], mdl[w + 1], mdl[w]};
  endfunction

  // One bus cycle: present an address phase, carry the previous transfer's data phase, then score it.
  task automatic bus(input bit sel, input bit rdy, input logic [1:0] trans, input bit wr,
                     input logic [2:0] size, input logic [31:0] addr, input logic [31:0] wdata);
    hsel   = sel;
    hready = rdy;
    htrans = trans;
    hwrite = wr;
    hsize  = size;
    haddr  = addr;
    hburst = 3'($urandom);
    dft_en = 1'($urandom);
    hwdata = (pend_vld && pend_wr) ? pend_wdata : $urandom;
    @(posedge hclk);
    #1;
    check("hready_resp", {31'd0, hready_resp}, 32'd1);
    check("hresp", {30'd0, hresp}, 32'd0);
    if (pend_vld) begin
      if (pend_wr) mdl_write(pend_addr, pend_size, pend_wdata);
      else         check("read", hrdata, mdl_read(pend_addr));
    end
    pend_vld   = sel && rdy && trans[1];
    pend_wr    = wr;
    pend_size  = size;
    pend_addr  = addr;
    pend_wdata = wdata;
  endtask

  task automatic idle();
    bus(1'b0, 1'b1, 2'b00, 1'b0, 3'd0, 32'd0, 32'd0);
  endtask

  task automatic wr(input logic [2:0] size, input logic [31:0] addr, input logic [31:0] d);
    bus(1'b1, 1'b1, 2'b10, 1'b1, size, addr, d);
  endtask

  task automatic rd(input logic [31:0] addr);
    bus(1'b1, 1'b1, 2'b10, 1'b0, 3'd2, addr, 32'd0);
  endtask

  initial begin
    hresetn = 1'b0;
    hsel = 1'b0; hwrite = 1'b0; hready = 1'b1; hsize = 3'd0; hburst = 3'd0;
    htrans = 2'b00; hwdata = 32'd0; haddr = 32'd0; dft_en = 1'b0; bist_en = 1'b0;
    repeat (3) @(posedge hclk);
    #1;
    check("rst_hrdata", hrdata, 32'd0);
    check("rst_hready_resp", {31'd0, hready_resp}, 32'd1);
    check("rst_hresp", {30'd0, hresp}, 32'd0);
    check("rst_bist_done", {31'd0, bist_done}, 32'd0);
    check("rst_bist_fail", {31'd0, bist_fail}, 32'd0);
    hresetn = 1'b1;
    idle();

    wr(3'd2, 32'h10, 32'hDEAD_BEEF); idle(); rd(32'h10); idle();
    check("word_rd", hrdata, 32'hDEAD_BEEF);

    wr(3'd0, 32'h20, 32'h0000_0011); wr(3'd0, 32'h21, 32'h0000_2200);
    wr(3'd0, 32'h22, 32'h0033_0000); wr(3'd0, 32'h23, 32'h4400_0000);
    rd(32'h20); idle();
    check("byte_lanes", hrdata, 32'h4433_2211);

    wr(3'd2, 32'h30, 32'h0); wr(3'd1, 32'h32, 32'hABCD_1234); rd(32'h30); idle();
    check("half_upper", hrdata, 32'hABCD_0000);

    wr(3'd2, 32'h40, 32'h1234_5678); rd(32'h40); wr(3'd2, 32'h44, 32'h0BAD_0BAD); idle();
    check("b2b_hold", hrdata, 32'h1234_5678);

    wr(3'd2, 32'h50, 32'hCAFE_F00D); idle();
    bus(1'b1, 1'b1, 2'b00, 1'b1, 3'd2, 32'h50, 32'hFFFF_FFFF);
    bus(1'b1, 1'b1, 2'b01, 1'b1, 3'd2, 32'h50, 32'hFFFF_FFFF);
    bus(1'b0, 1'b1, 2'b10, 1'b1, 3'd2, 32'h50, 32'hFFFF_FFFF);
    bus(1'b1, 1'b0, 2'b10, 1'b1, 3'd2, 32'h50, 32'hFFFF_FFFF);
    rd(32'h50); idle();
    check("ignored_wr", hrdata, 32'hCAFE_F00D);

    // Reset lands inside the data phase of the second write to 0x60.
    wr(3'd2, 32'h60, 32'h1111_1111); idle(); wr(3'd2, 32'h60, 32'h9999_9999);
    hsel = 1'b0; htrans = 2'b00; hwdata = 32'h9999_9999;
    #2;
    hresetn = 1'b0;
    #1;
    check("rst_mid_hrdata", hrdata, 32'd0);
    @(posedge hclk);
    #1;
    hresetn = 1'b1;
    pend_vld = 1'b0;
    rd(32'h60); idle();
    check("rst_mid_word", hrdata, 32'h1111_1111);

    for (int w = 0; w < 64; w++) wr(3'd2, 32'h200 + 32'(4 * w), $urandom);
    for (int i = 0; i < 400; i++) begin
      int r;
      logic [1:0] t;
      bit s, y;
      r = $urandom_range(0, 9);
      t = (r == 0) ? 2'b00 : (r == 1) ? 2'b01 : (r < 6) ? 2'b10 : 2'b11;
      s = ($urandom_range(0, 9) != 0);
      y = pend_vld ? 1'b1 : ($urandom_range(0, 7) != 0);
      bus(s, y, t, 1'($urandom), 3'($urandom_range(0, 3)),
          {16'($urandom), 16'h0200 + 16'($urandom_range(0, 255))}, $urandom);
    end
    idle();

`ifdef SRAMC_BIST_EN
    bist_en = 1'b1;
    repeat (2) @(posedge hclk);
    #1;
    check("bist_busy", {31'd0, hready_resp}, 32'd0);
    begin
      int n;
      n = 0;
      while (!bist_done && n < 70000) begin
        @(posedge hclk);
        n++;
      end
      #1;
    end
    check("bist_done", {31'd0, bist_done}, 32'd1);
    check("bist_fail", {31'd0, bist_fail}, 32'd0);
    check("bist_rdy", {31'd0, hready_resp}, 32'd1);
    bist_en = 1'b0;
    @(posedge hclk);
    #1;
    check("bist_done_clr", {31'd0, bist_done}, 32'd0);
`else
    bist_en = 1'b1;
    repeat (4) @(posedge hclk);
    #1;
    check("nobist_rdy", {31'd0, hready_resp}, 32'd1);
    check("nobist_done", {31'd0, bist_done}, 32'd0);
    check("nobist_fail", {31'd0, bist_fail}, 32'd0);
    bist_en = 1'b0;
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
